seq_divider_8by4: RTL and testbench
===================================

// Module: seq_divider_8by4
// PURPOSE
//  Iterative restoring divider: unsigned DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor -> quotient + remainder.
//  Inverse of the 4x4 array multiplier: for any product p = a*b with b != 0, p / b returns a, r = 0.
//  Produces one quotient bit per clock. Sits between operand source and result sink, valid/ready on both sides.
// PARAMETERS
//  DIVIDEND_W  8  dividend and quotient width
//  DIVISOR_W   4  divisor and remainder width; DIVISOR_W <= DIVIDEND_W required
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           operands valid
//  in_ready   out  1           block can accept operands
//  dividend   in   DIVIDEND_W  unsigned dividend
//  divisor    in   DIVISOR_W   unsigned divisor
//  out_valid  out  1           result valid
//  out_ready  in   1           sink accepts result
//  quotient   out  DIVIDEND_W  unsigned quotient
//  remainder  out  DIVISOR_W   unsigned remainder
//  dbz        out  1           divide-by-zero flag; only with SEQ_DIV_DBZ_EN, else tied 0
// BEHAVIOUR
//  FSM states: IDLE, RUN, DONE. Reset: state IDLE, quotient/remainder/out_valid/dbz = 0, count = 0.
//  in_ready = (state == IDLE), combinational; high during reset. out_valid = (state == DONE).
//  IDLE: on in_valid & in_ready at edge T: latch operands, partial remainder P = 0, count = 0, go RUN.
//  RUN, each edge: P' = {P, next dividend MSB}, (DIVISOR_W+1) bits; if P' >= divisor: P = P' - divisor, qbit = 1,
//   else P = P', qbit = 0; shift qbit into quotient LSB; count++. After DIVIDEND_W steps go DONE.
//  Latency: out_valid high from edge T + DIVIDEND_W (8 cycles at defaults) after acceptance.
//  DONE: quotient/remainder held stable while out_valid and out_ready low; on out_valid & out_ready -> IDLE.
//  No overlap: new operands cannot be accepted in RUN or DONE; next accept is earliest 1 cycle after result handshake.
//  in_valid ignored outside IDLE; operand inputs sampled only at acceptance edge.
//  divisor = 0 without macro: normal DIVIDEND_W-cycle run gives quotient = all ones,
//   remainder = dividend[DIVISOR_W-1:0].
//  Reset asserted mid-RUN or mid-DONE: immediate return to IDLE, result discarded, all outputs to reset values.
//  Remainder always < divisor when divisor != 0; no overflow possible.
// CONFIGURATION
//  SEQ_DIV_DBZ_EN defined: divisor = 0 at acceptance -> skip RUN, enter DONE next edge (1-cycle latency),
//   quotient = all ones, remainder = dividend[DIVISOR_W-1:0], dbz = 1 while out_valid; dbz cleared on leaving DONE.
//  Undefined: no early exit, dbz tied 0, result values as in BEHAVIOUR.
// STRUCTURE
//  Package seq_div_pkg: state enum (IDLE/RUN/DONE), default widths, count width = $clog2(DIVIDEND_W+1).
//  Sub-module div_step: combinational one-bit restoring stage (P_in, dividend bit, divisor -> P_out, qbit).
//  Top holds FSM, counter, dividend shift register, quotient register, handshake logic.
// TESTING
//  200 / 7 -> quotient 28, remainder 4, out_valid exactly 8 cycles after accept edge.
//  255 / 15 -> 17 r 0; 100 / 1 -> 100 r 0; 0 / 5 -> 0 r 0.
//  13 / 0 -> quotient 0xFF, remainder 0xD; with SEQ_DIV_DBZ_EN dbz = 1 and 1-cycle latency, else dbz = 0 and 8 cycles.
//  Back-pressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready 0, in_valid pulses ignored.
//  rst_n low at RUN step 4 -> next sample: state IDLE, in_ready 1, out_valid 0; following 45/6 -> 7 r 3.
//  Exhaustive: all 256 x 15 nonzero pairs vs. reference model; every (a*b)/b for 4-bit a, b != 0 returns a r 0.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_div_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;
    localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width for a given dividend width.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_8by4_div_step.sv
// One restoring-division bit: shift a dividend bit into the partial remainder, subtract if it fits.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
// Ports: p_in (partial remainder), dvd_bit (next dividend MSB), divisor -> p_out, q_bit.
module div_step
    import seq_div_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W-1:0] p_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] p_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] p_ext;

    assign p_ext = {p_in, dvd_bit};
    assign q_bit = (p_ext >= {1'b0, divisor});

    // When the subtraction is taken the true difference is < divisor, so the
    // low DIVISOR_W bits of the modular difference are exact. With a zero
    // divisor the shifted value is kept truncated, which leaves the low
    // dividend bits in the remainder after a full run.
    assign p_out = q_bit ? (p_ext[DIVISOR_W-1:0] - divisor) : p_ext[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_8by4.sv
// Iterative restoring divider: unsigned dividend / divisor -> quotient, remainder, one quotient bit per clock.
// Latency: out_valid rises DIVIDEND_W edges after the accept edge (1 edge for divide-by-zero when SEQ_DIV_DBZ_EN).
// Backpressure: single transaction in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/dividend/divisor; out_valid/out_ready/quotient/remainder/dbz.
// Build option: define SEQ_DIV_DBZ_EN for the divide-by-zero early exit and dbz flag (otherwise dbz is tied 0).
module seq_divider_8by4
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF   // must not exceed DIVIDEND_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);

    localparam int               CNT_W    = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    div_state_t            state_q;
    div_state_t            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVIDEND_W-1:0] dvd_q;     // dividend, shifted left so the MSB is the next bit to consume
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  rem_q;     // partial remainder; final remainder once in DONE
    logic [DIVISOR_W-1:0]  p_next;
    logic                  q_bit;
    logic                  accept;
    logic                  step_en;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign quotient  = quo_q;
    assign remainder = rem_q;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p_in    (rem_q),
        .dvd_bit (dvd_q[DIVIDEND_W-1]),
        .divisor (dvs_q),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

`ifdef SEQ_DIV_DBZ_EN
    logic dbz_q;

    // A zero-divisor transaction parks in RUN for one cycle with the counter
    // preloaded to its last value, so it reaches DONE on the next edge
    // without touching the precomputed result.
    assign step_en = (state_q == RUN) && !dbz_q;
    assign dbz     = dbz_q & out_valid;
`else
    assign step_en = (state_q == RUN);
    assign dbz     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Datapath: operand capture and one restoring step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
`ifdef SEQ_DIV_DBZ_EN
            dbz_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                quo_q <= '0;
                cnt_q <= '0;
`ifdef SEQ_DIV_DBZ_EN
                dbz_q <= 1'b0;
                if (divisor == '0) begin
                    dbz_q <= 1'b1;
                    cnt_q <= LAST_CNT;
                    quo_q <= '1;
                    rem_q <= dividend[DIVISOR_W-1:0];
                end
`endif
            end else if (step_en) begin
                dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
                rem_q <= p_next;
                quo_q <= {quo_q[DIVIDEND_W-2:0], q_bit};
                cnt_q <= cnt_q + CNT_W'(1);
            end
`ifdef SEQ_DIV_DBZ_EN
            if ((state_q == DONE) && out_ready) begin
                dbz_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4: directed cases, back-pressure, mid-run reset,
// exhaustive operand sweep and randomized traffic against an arithmetic reference model.
// Runs in either build flavour; expectations follow SEQ_DIV_DBZ_EN when it is defined.
module tb_seq_divider_8by4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    int checks = 0;
    int errors = 0;

    seq_divider_8by4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; a zero divisor yields all-ones and the low dividend bits.
    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] eq, output logic [3:0] er,
                         output int elat, output logic edbz);
        if (b == 4'd0) begin
            eq = 8'hFF;
            er = a[3:0];
`ifdef SEQ_DIV_DBZ_EN
            elat = 1;
            edbz = 1'b1;
`else
            elat = 8;
            edbz = 1'b0;
`endif
        end else begin
            eq   = a / {4'd0, b};
            er   = 4'(a % {4'd0, b});
            elat = 8;
            edbz = 1'b0;
        end
    endtask

    // One full transaction; 'hold' cycles of out_ready low after out_valid,
    // during which stray in_valid pulses must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int hold, input bit full);
        logic [7:0] eq;
        logic [3:0] er;
        int         elat;
        logic       edbz;
        int         n;
        int         lat;
        model(a, b, eq, er, elat, edbz);
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (full) chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        if (full) chk("in_ready_after_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        if (full) chk("dbz", dbz, edbz);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_dbz", dbz, edbz);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_handshake_out_valid", out_valid, 0);
        if (full) begin
            chk("post_handshake_in_ready", in_ready, 1);
            chk("post_handshake_dbz", dbz, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(8'd200, 4'd7, 0, 1'b1);
        run_op(8'd255, 4'd15, 0, 1'b1);
        run_op(8'd100, 4'd1, 0, 1'b1);
        run_op(8'd0, 4'd5, 0, 1'b1);
        run_op(8'd13, 4'd0, 0, 1'b1);

        // Back-pressure with ignored in_valid pulses
        run_op(8'd200, 4'd7, 5, 1'b1);
        run_op(8'd13, 4'd0, 5, 1'b1);

        // Reset after four RUN steps
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_in_ready", in_ready, 1);
        chk("midrun_reset_out_valid", out_valid, 0);
        chk("midrun_reset_quotient", quotient, 0);
        chk("midrun_reset_remainder", remainder, 0);
        chk("midrun_reset_dbz", dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd45, 4'd6, 0, 1'b1);

        // Every (a*b)/b with 4-bit a and nonzero b returns a r 0
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                run_op(8'(a * b), 4'(b), 0, 1'b0);
            end
        end

        // Exhaustive sweep over all nonzero divisors
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_op(8'(a), 4'(b), 0, 1'b0);
            end
        end

        // Randomized traffic, zero divisor and back-pressure included
        for (int i = 0; i < 150; i++) begin
            run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
